// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The entry struct documents the default 32/32 layout pushed into the FIFO.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO for fetched {pc, inst} entries.
// Push and pop may coincide at any occupancy; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // NOTE: the storage is only DEPTH entries, so it is reset along with the
  // pointers; that way the head outputs read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: issues one read at a time to instruction memory and queues the
// returned words with their addresses for decode; redirects flush everything.
module inst_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirValid,
  input  logic [ADDR_W-1:0] redirPc,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRvalid,
  input  logic [DATA_W-1:0] memRdata,
  output logic              instValid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] instPc,
  input  logic              instReady,
  output logic [ADDR_W-1:0] fetchPc
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   redir_target;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_valid;
  logic                push;
  logic                pop;
  logic                room_after;

  assign redir_target = redirPc & ~ADDR_W'(3);
  assign pop          = instValid && instReady;
  assign push         = (state == WAIT) && memRvalid && !redirValid;
  // Occupancy after this cycle's push and pop decides whether to fetch again.
  assign room_after   = (int'(count) + int'(push) - int'(pop)) < DEPTH;

  // NOTE: next-state logic uses blocking assignments and starts from a default,
  // so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count < CNT_W'(DEPTH)) state_nxt = REQ;
      REQ:     if (memGnt) state_nxt = WAIT;
      WAIT:    if (memRvalid) state_nxt = room_after ? REQ : IDLE;
      DROP:    if (memRvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirValid) begin
      // A read already accepted by memory must have its response swallowed.
      if ((state == REQ && memGnt) || (state == WAIT && !memRvalid) ||
          (state == DROP && !memRvalid))
        state_nxt = DROP;
      else
        state_nxt = IDLE;
    end
  end

  // NOTE: all state registers use non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirValid) pc <= redir_target;
      else if (push)  pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirValid),
    .push      (push),
    .push_data ({pc, memRdata}),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .count     (count)
  );

  assign memReq    = (state == REQ);
  assign memAddr   = pc;
  assign fetchPc   = pc;
  assign instValid = fifo_valid;
  assign instPc    = head[ENTRY_W-1 -: ADDR_W];
  assign inst      = head[DATA_W-1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a single-outstanding memory model
// whose response latency can be changed between scenarios.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirValid;
  logic [31:0] redirPc;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        instValid;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        instReady;
  logic [31:0] fetchPc;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];
  logic [31:0] gnt_q[$];
  logic [31:0] pend_addr;
  int          pend_cnt = 0;
  int          lat = 1;
  bit          last_gnt;
  int          n;
  int          g0;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (2),
    .RESET_PC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirValid (redirValid),
    .redirPc    (redirPc),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memGnt     (memGnt),
    .memRvalid  (memRvalid),
    .memRdata   (memRdata),
    .instValid  (instValid),
    .inst       (inst),
    .instPc     (instPc),
    .instReady  (instReady),
    .fetchPc    (fetchPc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample what the coming posedge will do, cross it, then update memory
  // response signals at the following negedge.
  task automatic cyc();
    last_gnt = 1'b0;
    if (instValid && instReady && !redirValid && !rst) begin
      log_pc.push_back(instPc);
      log_inst.push_back(inst);
    end
    if (memReq && memGnt && !rst) begin
      gnt_q.push_back(memAddr);
      pend_addr = memAddr;
      pend_cnt  = lat;
      last_gnt  = 1'b1;
    end
    @(negedge clk);
    memRvalid  = 1'b0;
    memRdata   = 32'hBAD0_BAD0;
    redirValid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        memRvalid = 1'b1;
        memRdata  = img(pend_addr);
      end
    end
  endtask

  task automatic clear_logs();
    log_pc.delete();
    log_inst.delete();
    gnt_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    redirValid = 1'b0;
    redirPc    = '0;
    memGnt     = 1'b1;
    memRvalid  = 1'b0;
    memRdata   = '0;
    instReady  = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_fetchpc", fetchPc, 32'h0);
    check("rst_memreq", memReq, 1'b0);
    check("rst_memaddr", memAddr, 32'h0);
    check("rst_instvalid", instValid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_instpc", instPc, 32'h0);
    rst = 1'b0;

    // 1: zero-wait grant, 1-cycle response, decode always ready
    instReady = 1'b1;
    n = 0;
    while (!memRvalid && n < 20) begin cyc(); n++; end
    check("t1_rvalid_seen", memRvalid, 1'b1);
    cyc();
    check("t1_latency_valid", instValid, 1'b1);
    check("t1_first_pc", instPc, 32'h0);
    n = 0;
    while (log_pc.size() < 4 && n < 40) begin cyc(); n++; end
    check("t1_count", log_pc.size(), 4);

    // 2: decode stalls, FIFO fills, fetching stops, then resumes
    instReady = 1'b0;
    g0 = gnt_q.size();
    repeat (10) cyc();
    check("t2_stall_grants", gnt_q.size() - g0, 1);
    check("t2_stall_memreq", memReq, 1'b0);
    check("t2_stall_valid", instValid, 1'b1);
    check("t2_stall_head", instPc, 32'h10);
    instReady = 1'b1;
    n = 0;
    while (log_pc.size() < 8 && n < 60) begin cyc(); n++; end
    check("t2_count", log_pc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_pc%0d", i), log_pc[i], 32'(4 * i));
      check($sformatf("t2_inst%0d", i), log_inst[i], img(32'(4 * i)));
    end

    // 3: redirect while waiting for a slow response
    lat = 3;
    g0 = gnt_q.size();
    n = 0;
    while (gnt_q.size() == g0 && n < 20) begin cyc(); n++; end
    redirValid = 1'b1;
    redirPc    = 32'h103;
    cyc();
    check("t3_fetchpc", fetchPc, 32'h100);
    check("t3_flushed", instValid, 1'b0);
    check("t3_no_req", memReq, 1'b0);
    clear_logs();
    n = 0;
    while (log_pc.size() < 2 && n < 40) begin cyc(); n++; end
    check("t3_gnt_addr", gnt_q[0], 32'h100);
    check("t3_pc0", log_pc[0], 32'h100);
    check("t3_inst0", log_inst[0], img(32'h100));
    check("t3_pc1", log_pc[1], 32'h104);

    // 4: redirect coinciding with a response, one entry already queued
    lat        = 1;
    instReady  = 1'b0;
    redirValid = 1'b1;
    redirPc    = 32'h200;
    cyc();
    n = 0;
    while (!(memRvalid && instValid) && n < 30) begin cyc(); n++; end
    check("t4_reached", memRvalid && instValid, 1'b1);
    check("t4_head_pc", instPc, 32'h200);
    redirValid = 1'b1;
    redirPc    = 32'h300;
    cyc();
    check("t4_empty", instValid, 1'b0);
    check("t4_fetchpc", fetchPc, 32'h300);
    clear_logs();
    instReady = 1'b1;
    n = 0;
    while (log_pc.size() < 1 && n < 30) begin cyc(); n++; end
    check("t4_gnt_addr", gnt_q[0], 32'h300);
    check("t4_pc0", log_pc[0], 32'h300);

    // 5: reset in the middle of a wait; the late response must be ignored
    lat       = 3;
    instReady = 1'b0;
    n = 0;
    while (!(last_gnt && instValid) && n < 30) begin cyc(); n++; end
    check("t5_reached", last_gnt && instValid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_fetchpc", fetchPc, 32'h0);
    check("t5_memaddr", memAddr, 32'h0);
    check("t5_memreq", memReq, 1'b0);
    check("t5_instvalid", instValid, 1'b0);
    check("t5_inst", inst, 32'h0);
    check("t5_instpc", instPc, 32'h0);
    cyc();
    rst = 1'b0;
    clear_logs();
    cyc();
    check("t5_late_rvalid", memRvalid, 1'b1);
    check("t5_stale_ignored", instValid, 1'b0);
    check("t5_restart_addr", memAddr, 32'h0);
    instReady = 1'b1;
    n = 0;
    while (log_pc.size() < 2 && n < 40) begin cyc(); n++; end
    check("t5_gnt_addr", gnt_q[0], 32'h0);
    check("t5_pc0", log_pc[0], 32'h0);
    check("t5_inst0", log_inst[0], img(32'h0));
    check("t5_pc1", log_pc[1], 32'h4);

    // 6: fetch address wraps past the top of the address space
    lat        = 1;
    redirValid = 1'b1;
    redirPc    = 32'hFFFF_FFFC;
    cyc();
    clear_logs();
    n = 0;
    while (log_pc.size() < 2 && n < 40) begin cyc(); n++; end
    check("t6_pc0", log_pc[0], 32'hFFFF_FFFC);
    check("t6_inst0", log_inst[0], img(32'hFFFF_FFFC));
    check("t6_pc1", log_pc[1], 32'h0);
    check("t6_inst1", log_inst[1], img(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
